// File: rtl/cache_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single cache request port.
// One transaction at a time: IDLE grants, BUSY waits for the cache, DONE pulses ready.
module cache_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick;

  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    // Under contention round-robin favours the port that did not win last time.
    pick = d_valid;
    if (i_valid && d_valid) begin
      pick = (ROUND_ROBIN != 0) ? ~last_grant_q : GRANT_D;
    end

    unique case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          state_d      = BUSY;
          mem_valid_d  = 1'b1;
          grant_d      = pick;
          last_grant_d = pick;
          if (pick == GRANT_D) begin
            mem_addr_d  = d_addr;
            mem_wmask_d = d_wmask;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = i_addr;
            mem_wmask_d = '0;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_valid_d = 1'b0;
          if (grant_q == GRANT_D) begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_I;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a transaction-level model predicts grant order, latched request fields and read data.
module tb_cache_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, d_valid, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;

  logic        a_i_ready, a_d_ready, a_mem_valid, b_i_ready, b_d_ready, b_mem_valid;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  a_mem_wmask, b_mem_wmask;

  always #5 clk = ~clk;

  cache_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(a_i_ready), .i_addr(i_addr), .i_rdata(a_i_rdata),
    .d_valid(d_valid), .d_ready(a_d_ready), .d_addr(d_addr), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_rdata(a_d_rdata),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
    .mem_wmask(a_mem_wmask), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  cache_arbiter #(.ROUND_ROBIN(0)) u_fix (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(b_i_ready), .i_addr(i_addr), .i_rdata(b_i_rdata),
    .d_valid(d_valid), .d_ready(b_d_ready), .d_addr(d_addr), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_rdata(b_d_rdata),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
    .mem_wmask(b_mem_wmask), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
  );

  // Model state: which instance is observed, outstanding requests, expected data.
  bit          rr_m;
  bit          i_pend, d_pend, last_m;
  logic [31:0] ia, da, dw, ir_m, dr_m;
  logic [3:0]  dm;
  int          total = 0;
  int          bad = 0;

  logic        o_i_ready, o_d_ready, o_mem_valid;
  logic [31:0] o_i_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wmask;

  assign o_i_ready   = rr_m ? a_i_ready   : b_i_ready;
  assign o_d_ready   = rr_m ? a_d_ready   : b_d_ready;
  assign o_mem_valid = rr_m ? a_mem_valid : b_mem_valid;
  assign o_i_rdata   = rr_m ? a_i_rdata   : b_i_rdata;
  assign o_d_rdata   = rr_m ? a_d_rdata   : b_d_rdata;
  assign o_mem_addr  = rr_m ? a_mem_addr  : b_mem_addr;
  assign o_mem_wdata = rr_m ? a_mem_wdata : b_mem_wdata;
  assign o_mem_wmask = rr_m ? a_mem_wmask : b_mem_wmask;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s rr=%0d observed=%h expected=%h", tag, rr_m, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_valid"}, 32'(o_mem_valid), 32'd0);
    chk({tag, "_ready"}, 32'({o_i_ready, o_d_ready}), 32'd0);
    chk({tag, "_i_rdata"}, o_i_rdata, ir_m);
    chk({tag, "_d_rdata"}, o_d_rdata, dr_m);
  endtask

  task automatic do_reset;
    reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; last_m = 1'b0; ir_m = '0; dr_m = '0;
    tick;
    reset = 1'b0;
  endtask

  task automatic new_req_i(input logic [31:0] a);
    i_pend = 1'b1; ia = a; i_valid = 1'b1; i_addr = a;
    if (!d_pend) begin
      d_wmask = 4'($urandom_range(15)); d_wdata = $urandom;
    end
  endtask

  task automatic new_req_d(input logic [31:0] a, input logic [3:0] m, input logic [31:0] w);
    d_pend = 1'b1; da = a; dm = m; dw = w;
    d_valid = 1'b1; d_addr = a; d_wmask = m; d_wdata = w;
  endtask

  // One full transaction from the IDLE sampling edge to the IDLE cycle after DONE.
  task automatic txn(input int lat, input bit drop, input logic [31:0] rd, output bit g_obs);
    bit          pick;
    logic [31:0] exp_addr;
    pick = (i_pend && d_pend) ? (rr_m ? !last_m : 1'b1) : d_pend;
    exp_addr = pick ? da : ia;
    tick;
    chk("grant_mem_valid", 32'(o_mem_valid), 32'd1);
    chk("grant_mem_addr", o_mem_addr, exp_addr);
    chk("grant_mem_wmask", 32'(o_mem_wmask), pick ? 32'(dm) : 32'd0);
    chk("grant_mem_wdata", o_mem_wdata, pick ? dw : 32'd0);
    last_m = pick;
    for (int k = 0; k < lat; k++) begin
      if (drop && k == 0) begin
        if (pick) begin d_valid = 1'b0; d_addr = $urandom; end
        else begin i_valid = 1'b0; i_addr = $urandom; end
      end
      tick;
      chk("busy_mem_valid", 32'(o_mem_valid), 32'd1);
      chk("busy_mem_addr", o_mem_addr, exp_addr);
      chk("busy_ready", 32'({o_i_ready, o_d_ready}), 32'd0);
    end
    mem_ready = 1'b1; mem_rdata = rd;
    tick;
    mem_ready = 1'b0;
    if (pick) dr_m = rd; else ir_m = rd;
    g_obs = o_d_ready;
    chk("done_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("done_i_ready", 32'(o_i_ready), 32'(!pick));
    chk("done_d_ready", 32'(o_d_ready), 32'(pick));
    chk("done_i_rdata", o_i_rdata, ir_m);
    chk("done_d_rdata", o_d_rdata, dr_m);
    if (pick) begin d_valid = 1'b0; d_pend = 1'b0; end
    else begin i_valid = 1'b0; i_pend = 1'b0; end
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    tick;
    mem_ready = 1'b0;
    chk_quiet("gap");
  endtask

  task automatic idle_tick(input bit spur);
    mem_ready = spur; mem_rdata = $urandom;
    tick;
    mem_ready = 1'b0;
    chk_quiet("idle");
  endtask

  task automatic contention;
    bit g;
    do_reset;
    new_req_i($urandom);
    new_req_d($urandom, 4'($urandom_range(15)), $urandom);
    for (int k = 0; k < 4; k++) begin
      txn(1, 1'b0, $urandom, g);
      chk("contention_grant", 32'(g), rr_m ? 32'((k % 2) == 0) : 32'd1);
      if (!d_pend) new_req_d($urandom, 4'($urandom_range(15)), $urandom);
      if (!i_pend) new_req_i($urandom);
    end
    if (!rr_m) begin
      d_valid = 1'b0; d_pend = 1'b0;
      txn(0, 1'b0, $urandom, g);
      chk("contention_imem_last", 32'(g), 32'd0);
    end
  endtask

  task automatic random_run(input int n);
    bit g;
    for (int it = 0; it < n; it++) begin
      if (!i_pend && ($urandom % 2 == 0)) new_req_i($urandom);
      if (!d_pend && ($urandom % 3 == 0))
        new_req_d($urandom, ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(15)), $urandom);
      if (i_pend || d_pend) txn(int'($urandom_range(4)), ($urandom % 4) == 0, $urandom, g);
      else idle_tick(1'($urandom));
    end
  endtask

  initial begin
    bit g;
    rr_m = 1'b1;
    i_addr = '0; d_addr = '0; d_wmask = '0; d_wdata = '0; mem_rdata = '0;
    do_reset;
    chk("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_wmask", 32'(o_mem_wmask), 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_ready", 32'({o_i_ready, o_d_ready}), 32'd0);
    chk("rst_rdata", o_i_rdata | o_d_rdata, 32'd0);

    // Single data read, cache answers after 3 busy cycles.
    new_req_d(32'h100, 4'h0, 32'h0);
    txn(3, 1'b0, 32'hDEADBEEF, g);
    chk("read_d_rdata", o_d_rdata, 32'hDEADBEEF);

    // Instruction fetch with write data lingering on the idle data port.
    new_req_i(32'h2000);
    d_wmask = 4'hF; d_wdata = 32'h12345678;
    txn(2, 1'b0, 32'hCAFEF00D, g);
    chk("fetch_d_rdata_kept", o_d_rdata, 32'hDEADBEEF);
    chk("fetch_i_rdata", o_i_rdata, 32'hCAFEF00D);

    // Spurious cache completion while idle, then a normal write.
    idle_tick(1'b1);
    new_req_d(32'h300, 4'h3, 32'hA5A5A5A5);
    txn(1, 1'b0, 32'h0BADC0DE, g);

    // Reset in the middle of a busy transaction, then a stale completion.
    new_req_d(32'h400, 4'h0, 32'h0);
    tick;
    chk("abort_grant", 32'(o_mem_valid), 32'd1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; d_valid = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; last_m = 1'b0; ir_m = '0; dr_m = '0;
    chk("abort_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("abort_ready", 32'({o_i_ready, o_d_ready}), 32'd0);
    idle_tick(1'b1);
    idle_tick(1'b0);

    contention;
    random_run(150);

    rr_m = 1'b0;
    contention;
    random_run(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning 1 = alternate grant under contention, 0 = dmem port always wins.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  instruction-port request; held high with i_addr stable until i_ready.
REQ-005 i_ready  output  1  one-cycle completion pulse for instruction port.
REQ-006 i_addr  input  32  instruction byte address.
REQ-007 i_rdata  output  32  instruction read data.
REQ-008 d_valid  input  1  data-port request; held high with d_addr/d_wmask/d_wdata stable until d_ready.
REQ-009 d_ready  output  1  one-cycle completion pulse for data port.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wmask  input  4  byte write enables; 0 = read.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_rdata  output  32  data read data.
REQ-014 mem_valid  output  1  request to cache_control; held until mem_ready.
REQ-015 mem_ready  input  1  cache completion pulse.
REQ-016 mem_addr  output  32  latched address of granted port.
REQ-017 mem_wmask  output  4  latched wmask; always 0 for instruction grants.
REQ-018 mem_wdata  output  32  latched wdata; always 0 for instruction grants.
REQ-019 mem_rdata  input  32  cache read data, valid in mem_ready cycle.

Function
REQ-020 FSM states IDLE, BUSY, DONE; encoding free.
REQ-021 IDLE, neither valid: stay IDLE, mem_valid low.
REQ-022 IDLE, one valid: grant that port next edge; latch its addr/wmask/wdata onto mem_* registers; mem_valid=1; go BUSY.
REQ-023 IDLE, both valid, ROUND_ROBIN=1: grant port opposite last_grant; ROUND_ROBIN=0: grant dmem.
REQ-024 last_grant register updated on every grant to the granted port.
REQ-025 Latency: mem_valid high exactly 1 cycle after the IDLE cycle in which the request is sampled.
REQ-026 BUSY: mem_valid and mem_* held constant; requester inputs not re-sampled.
REQ-027 BUSY with mem_ready: next edge mem_valid=0, mem_rdata captured into granted port's rdata register, granted port's ready=1, go DONE.
REQ-028 DONE: granted ready high this single cycle only; all valids ignored; next edge ready=0, go IDLE.
REQ-029 Minimum requester-visible latency (i_valid/d_valid high to ready pulse) = cache latency + 2 cycles; back-to-back transactions separated by at least one IDLE cycle with mem_valid low.
REQ-030 i_ready and d_ready never high in the same cycle; ready never pulses for the non-granted port.
REQ-031 i_rdata/d_rdata hold value until that port's next completion; other port's completion leaves it unchanged.
REQ-032 mem_ready outside BUSY ignored; no state or output change.
REQ-033 Requester dropping valid during BUSY: transaction still completes and ready still pulses.
REQ-034 Waiting port with valid held is granted no later than the transaction after the current one when ROUND_ROBIN=1 (no starvation).

Reset
REQ-035 reset high at an edge: state=IDLE, mem_valid=0, mem_addr/mem_wmask/mem_wdata=0, i_ready=d_ready=0, i_rdata=d_rdata=0, last_grant=imem; reset overrides all other conditions.
REQ-036 reset during BUSY or DONE: transaction abandoned, no ready pulse issued, mem_valid low from the next cycle.

Verification
REQ-037 Single read: d_valid=1, d_addr=0x100, d_wmask=0, cache returns 0xDEADBEEF after 3 cycles -> mem_valid 1 cycle after request, mem_addr=0x100, d_ready single pulse, d_rdata=0xDEADBEEF, i_ready stays 0.
REQ-038 Instruction fetch with d_wmask=0xF, d_wdata=0x12345678 present but d_valid=0 -> mem_wmask=0, mem_wdata=0, i_rdata updated, d_rdata unchanged.
REQ-039 Contention after reset, ROUND_ROBIN=1, both valids held -> grants dmem, imem, dmem, imem; one IDLE gap with mem_valid=0 between each.
REQ-040 Same contention, ROUND_ROBIN=0 -> dmem granted every transaction while d_valid held; imem waits.
REQ-041 Reset asserted in BUSY before mem_ready -> next cycle mem_valid=0, no ready pulse; a late mem_ready after reset causes no output change.
REQ-042 Spurious mem_ready in IDLE, then d_valid -> first pulse ignored; data transaction completes normally with correct d_rdata.
